lfsr_rand_gen: RTL and testbench
================================

Name: lfsr_rand_gen

Overview:
- Parametrised XNOR Fibonacci LFSR with the following features:
  - runtime seed load
  - lockup detection and recovery
  - period-wrap flag
  - request/valid "draw" handshake that advances the register a fixed number of steps per random value
- Supplies random values to game logic, e.g. computer-player press timing, compared against a difficulty threshold downstream.
- Generalises the fixed 10-bit generator to any width and tap set.

Parameters:
- WIDTH, 10, register width in bits; legal range 3..32.
- TAPS, 10'h009, WIDTH-bit tap mask; bit i set means state[i] feeds the XNOR. The default gives a maximal-length sequence for WIDTH=10.
- SEED, 0, reset and recovery state; must not be all-ones.
- STEPS, 1, shifts per draw; legal range 1..WIDTH.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  free-running advance; one shift per cycle while high and FSM is IDLE.
- load  in  1  load seed_in into the state register.
- seed_in  in  WIDTH  value loaded when load=1.
- draw_req  in  1  request one random value; sampled only in IDLE.
- draw_busy  out  1  high while the draw FSM is not IDLE.
- draw_valid  out  1  one-cycle pulse; draw_value is valid in that cycle.
- draw_value  out  WIDTH  registered value of the last completed draw; holds until the next draw.
- state_out  out  WIDTH  current LFSR state.
- lockup  out  1  one-cycle pulse when lockup recovery occurs.
- period_wrap  out  1  one-cycle pulse when a shift lands back on SEED.

Behaviour:
- Feedback and shift:
  - fb = ~^(state & TAPS)
  - shift: state <= {fb, state[WIDTH-1:1]}
- Lockup:
  - The lockup state is all-ones.
  - A shift attempted from all-ones instead loads SEED and pulses lockup.
  - That event does not pulse period_wrap.
- period_wrap pulses in the cycle after any normal shift whose result equals SEED.
- Priority per edge: reset > load > draw FSM > en.
- Reset:
  - state=SEED, FSM=IDLE.
  - draw_valid=0, draw_value=0, lockup=0, period_wrap=0.
  - draw_busy=0 (combinational from FSM).
- Load:
  - state <= seed_in with no shift.
  - Any draw in progress is aborted: FSM to IDLE, no draw_valid.
  - Loading all-ones is accepted; the next shift recovers to SEED and pulses lockup.
- Draw FSM has states IDLE and STEP; cnt is a register of width clog2(WIDTH+1).
  - IDLE & draw_req & !load:
    - shift now and set cnt=STEPS-1.
    - If STEPS==1, also set draw_value<=next state and draw_valid<=1, then stay in IDLE.
    - Otherwise go to STEP.
  - STEP:
    - shift each cycle and decrement cnt.
    - When cnt==1, set draw_value<=next state, draw_valid<=1, and go to IDLE.
  - Latency: draw_valid is high STEPS cycles after the req cycle; draw_busy is high for STEPS-1 cycles.
  - draw_req while busy is ignored, not queued. en while busy is ignored; the draw owns the shifter.
  - draw_req in the same cycle as draw_valid in IDLE is accepted (back-to-back draws).
- Lockup recovery inside a draw counts as one step.
- Outputs lockup, period_wrap and draw_valid are registered, with no combinational path from inputs.

Decomposition:
- lfsr_pkg holds:
  - draw_state_t enum (IDLE, STEP)
  - maximal-length tap constants for widths 3..32 (e.g. TAPS_10 = 10'h009)
  - an all-ones helper function
- Sub-module lfsr_core (parameters WIDTH, TAPS, SEED) is natural:
  - inputs: clk, reset, shift, load, seed_in
  - outputs: state, lockup, period_wrap
  - The draw FSM lives in lfsr_rand_gen.

Test Plan:
1. Reset, then en=1 for 8 cycles (defaults) -> state_out sequence 0x200, 0x300, 0x380, 0x3C0, 0x3E0, 0x3F0, 0x3F8, 0x1FC.
2. load seed_in=0x3FF, then en=1 for 1 cycle -> state_out=0x000 and lockup pulses once; the next en gives 0x200 with no lockup.
3. STEPS=3, reset, draw_req 1 cycle -> draw_busy high 2 cycles, draw_valid 1 cycle exactly 3 cycles after req, draw_value=0x380; en toggling during the draw has no effect.
4. Defaults, reset, en high 1023 cycles -> period_wrap pulses exactly once, on the 1023rd shift; state never equals 0x3FF; lockup never pulses.
5. STEPS=3, draw_req, then load seed_in=0x055 on the next cycle -> no draw_valid, FSM IDLE, state_out=0x055. load and draw_req in the same cycle -> load wins and the req is dropped.
6. STEPS=1, draw_req held high 4 cycles from reset -> draw_valid high 4 consecutive cycles, draw_value 0x200, 0x300, 0x380, 0x3C0; draw_busy stays 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types, tap constants and helpers for the LFSR random generator.
// Tap masks select state bits XNORed into the MSB on each right shift.
package lfsr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    STEP = 1'b1
  } draw_state_t;

  localparam logic [2:0]  TAPS_3  = 3'h3;
  localparam logic [3:0]  TAPS_4  = 4'h3;
  localparam logic [4:0]  TAPS_5  = 5'h05;
  localparam logic [5:0]  TAPS_6  = 6'h03;
  localparam logic [6:0]  TAPS_7  = 7'h03;
  localparam logic [7:0]  TAPS_8  = 8'h1D;
  localparam logic [8:0]  TAPS_9  = 9'h011;
  localparam logic [9:0]  TAPS_10 = 10'h009;
  localparam logic [10:0] TAPS_11 = 11'h005;
  localparam logic [11:0] TAPS_12 = 12'h941;
  localparam logic [12:0] TAPS_13 = 13'h1601;
  localparam logic [13:0] TAPS_14 = 14'h2A01;
  localparam logic [14:0] TAPS_15 = 15'h0003;
  localparam logic [15:0] TAPS_16 = 16'h100B;
  localparam logic [16:0] TAPS_17 = 17'h00009;
  localparam logic [17:0] TAPS_18 = 18'h00081;
  localparam logic [18:0] TAPS_19 = 19'h62001;
  localparam logic [19:0] TAPS_20 = 20'h00009;
  localparam logic [20:0] TAPS_21 = 21'h000005;
  localparam logic [21:0] TAPS_22 = 22'h000003;
  localparam logic [22:0] TAPS_23 = 23'h000021;
  localparam logic [23:0] TAPS_24 = 24'h000087;
  localparam logic [24:0] TAPS_25 = 25'h0000009;
  localparam logic [25:0] TAPS_26 = 26'h3100001;
  localparam logic [26:0] TAPS_27 = 27'h6400001;
  localparam logic [27:0] TAPS_28 = 28'h0000009;
  localparam logic [28:0] TAPS_29 = 29'h00000005;
  localparam logic [29:0] TAPS_30 = 30'h25000001;
  localparam logic [30:0] TAPS_31 = 31'h00000009;
  localparam logic [31:0] TAPS_32 = 32'hC0000401;

  // True when the low w bits of v are all ones (the XNOR lockup state).
  function automatic logic is_all_ones(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] m;
    if (w >= 32) m = 32'hFFFF_FFFF;
    else         m = (32'd1 << w) - 32'd1;
    return (v & m) == m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// XNOR Fibonacci shift register with seed load, lockup recovery, wrap flag.
// Ports: clk, reset, shift, load, seed_in -> state, lockup, period_wrap.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_10,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             lockup,
  output logic             period_wrap
);

  logic             w_fb;
  logic             w_lock;
  logic [WIDTH-1:0] w_next;

  assign w_fb   = ~^(state & TAPS);
  assign w_next = {w_fb, state[WIDTH-1:1]};
  assign w_lock = is_all_ones(32'(state), WIDTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEED;
      lockup      <= 1'b0;
      period_wrap <= 1'b0;
    end else begin
      lockup      <= 1'b0;
      period_wrap <= 1'b0;
      if (load) begin
        state <= seed_in;
      end else if (shift) begin
        // All-ones is a fixed point of XNOR feedback: jump to SEED.
        if (w_lock) begin
          state  <= SEED;
          lockup <= 1'b1;
        end else begin
          state       <= w_next;
          period_wrap <= (w_next == SEED);
        end
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// LFSR random source with a request/valid draw of STEPS shifts per value.
// Ports: clk, reset, en, load, seed_in, draw_req -> draw_*, state_out, flags.
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_10,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             draw_req,
  output logic             draw_busy,
  output logic             draw_valid,
  output logic [WIDTH-1:0] draw_value,
  output logic [WIDTH-1:0] state_out,
  output logic             lockup,
  output logic             period_wrap
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(STEPS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  draw_state_t      r_fsm;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic [WIDTH-1:0] r_value;

  logic             w_idle;
  logic             w_start;
  logic             w_shift;
  logic             w_done;
  logic             w_fb;
  logic [WIDTH-1:0] w_state;
  logic [WIDTH-1:0] w_nxt;

  assign w_idle  = (r_fsm == IDLE);
  assign w_start = w_idle & draw_req & ~load;

  // The draw owns the shifter; en only counts while idle.
  assign w_shift = ~load &
                   ((r_fsm == STEP) |
                    (w_idle & (draw_req | en)));

  assign w_done = ~load &
                  ((w_start & (STEPS == 1)) |
                   ((r_fsm == STEP) & (r_cnt == CNT_LAST)));

  // Value the core will hold after this edge's shift.
  assign w_fb  = ~^(w_state & TAPS);
  assign w_nxt = is_all_ones(32'(w_state), WIDTH) ?
                 SEED : {w_fb, w_state[WIDTH-1:1]};

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .shift       (w_shift),
    .load        (load),
    .seed_in     (seed_in),
    .state       (w_state),
    .lockup      (lockup),
    .period_wrap (period_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_value <= '0;
    end else begin
      r_valid <= 1'b0;
      if (load) begin
        r_fsm <= IDLE;
        r_cnt <= '0;
      end else begin
        case (r_fsm)
          IDLE: begin
            if (draw_req) begin
              r_cnt <= CNT_INIT;
              if (STEPS > 1) r_fsm <= STEP;
            end
          end
          STEP: begin
            r_cnt <= r_cnt - CNT_LAST;
            if (r_cnt == CNT_LAST) r_fsm <= IDLE;
          end
          default: r_fsm <= IDLE;
        endcase
      end
      if (w_done) begin
        r_value <= w_nxt;
        r_valid <= 1'b1;
      end
    end
  end

  assign draw_busy  = ~w_idle;
  assign draw_valid = r_valid;
  assign draw_value = r_value;
  assign state_out  = w_state;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench for lfsr_rand_gen (STEPS=1 and STEPS=3 instances).
// Directed scenarios plus a randomized run against a draw-level model.
module tb_lfsr_rand_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_en, a_load, a_req;
  logic [9:0] a_seed;
  logic       a_busy, a_valid, a_lock, a_wrap;
  logic [9:0] a_value, a_state;

  logic       b_en, b_load, b_req;
  logic [9:0] b_seed;
  logic       b_busy, b_valid, b_lock, b_wrap;
  logic [9:0] b_value, b_state;

  lfsr_rand_gen u_a (
    .clk(clk), .reset(rst), .en(a_en), .load(a_load),
    .seed_in(a_seed), .draw_req(a_req), .draw_busy(a_busy),
    .draw_valid(a_valid), .draw_value(a_value),
    .state_out(a_state), .lockup(a_lock), .period_wrap(a_wrap)
  );

  lfsr_rand_gen #(.STEPS(3)) u_b (
    .clk(clk), .reset(rst), .en(b_en), .load(b_load),
    .seed_in(b_seed), .draw_req(b_req), .draw_busy(b_busy),
    .draw_valid(b_valid), .draw_value(b_value),
    .state_out(b_state), .lockup(b_lock), .period_wrap(b_wrap)
  );

  // Reference: one step of the 10-bit XNOR LFSR, taps bits 0 and 3.
  task automatic model_adv(inout logic [9:0] s,
                           output logic l, output logic w);
    int p;
    l = 1'b0;
    w = 1'b0;
    if (s == 10'h3FF) begin
      s = 10'h000;
      l = 1'b1;
    end else begin
      p = (int'(s[0]) + int'(s[3])) % 2;
      s = 10'((int'(s) / 2) + ((p == 0) ? 512 : 0));
      w = (s == 10'h000);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    a_en = 0; a_load = 0; a_req = 0; a_seed = '0;
    b_en = 0; b_load = 0; b_req = 0; b_seed = '0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (a_state !== 10'h000 || a_busy !== 0 || a_valid !== 0 ||
        a_value !== 10'h000 || a_lock !== 0 || a_wrap !== 0) begin
      errors++;
      $display("FAIL reset_a: st=%h busy=%b v=%b val=%h lk=%b wr=%b want 000/0/0/000/0/0",
               a_state, a_busy, a_valid, a_value, a_lock, a_wrap);
    end
    checks++;
    if (b_state !== 10'h000 || b_busy !== 0 || b_valid !== 0 ||
        b_value !== 10'h000) begin
      errors++;
      $display("FAIL reset_b: st=%h busy=%b v=%b val=%h want 000/0/0/000",
               b_state, b_busy, b_valid, b_value);
    end
  endtask

  task automatic test_free_run;
    logic [9:0] exp [8] = '{10'h200, 10'h300, 10'h380, 10'h3C0,
                            10'h3E0, 10'h3F0, 10'h3F8, 10'h1FC};
    do_reset();
    a_en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (a_state !== exp[i]) begin
        errors++;
        $display("FAIL free_run[%0d]: got %h want %h", i, a_state, exp[i]);
      end
    end
    a_en = 0;
  endtask

  task automatic test_lockup;
    do_reset();
    a_load = 1; a_seed = 10'h3FF;
    tick();
    a_load = 0;
    checks++;
    if (a_state !== 10'h3FF || a_lock !== 0) begin
      errors++;
      $display("FAIL lock_load: st=%h lk=%b want 3ff/0", a_state, a_lock);
    end
    a_en = 1;
    tick();
    checks++;
    if (a_state !== 10'h000 || a_lock !== 1 || a_wrap !== 0) begin
      errors++;
      $display("FAIL lock_recover: st=%h lk=%b wr=%b want 000/1/0",
               a_state, a_lock, a_wrap);
    end
    tick();
    a_en = 0;
    checks++;
    if (a_state !== 10'h200 || a_lock !== 0) begin
      errors++;
      $display("FAIL lock_after: st=%h lk=%b want 200/0", a_state, a_lock);
    end
  endtask

  task automatic test_draw_steps3;
    do_reset();
    b_req = 1;
    tick();
    checks++;
    if (b_busy !== 1 || b_valid !== 0 || b_state !== 10'h200) begin
      errors++;
      $display("FAIL draw3_c1: busy=%b v=%b st=%h want 1/0/200",
               b_busy, b_valid, b_state);
    end
    b_req = 1; b_en = 1;
    tick();
    checks++;
    if (b_busy !== 1 || b_valid !== 0 || b_state !== 10'h300) begin
      errors++;
      $display("FAIL draw3_c2: busy=%b v=%b st=%h want 1/0/300",
               b_busy, b_valid, b_state);
    end
    b_req = 0; b_en = 0;
    tick();
    checks++;
    if (b_busy !== 0 || b_valid !== 1 || b_value !== 10'h380 ||
        b_state !== 10'h380) begin
      errors++;
      $display("FAIL draw3_c3: busy=%b v=%b val=%h st=%h want 0/1/380/380",
               b_busy, b_valid, b_value, b_state);
    end
    tick();
    checks++;
    if (b_busy !== 0 || b_valid !== 0 || b_value !== 10'h380 ||
        b_state !== 10'h380) begin
      errors++;
      $display("FAIL draw3_hold: busy=%b v=%b val=%h st=%h want 0/0/380/380",
               b_busy, b_valid, b_value, b_state);
    end
  endtask

  task automatic test_period;
    int wraps = 0, wrap_at = -1, ones = 0, locks = 0, bad = 0;
    logic [9:0] ms = 10'h000;
    logic ml, mw;
    do_reset();
    a_en = 1;
    for (int i = 1; i <= 1023; i++) begin
      tick();
      model_adv(ms, ml, mw);
      if (a_state !== ms) bad++;
      if (a_wrap === 1'b1) begin wraps++; wrap_at = i; end
      if (a_state === 10'h3FF) ones++;
      if (a_lock === 1'b1) locks++;
    end
    a_en = 0;
    checks++;
    if (wraps != 1 || wrap_at != 1023) begin
      errors++;
      $display("FAIL period_wrap: count=%0d at=%0d want 1 at 1023",
               wraps, wrap_at);
    end
    checks++;
    if (ones != 0 || locks != 0 || bad != 0) begin
      errors++;
      $display("FAIL period_seq: ones=%0d locks=%0d mism=%0d want 0/0/0",
               ones, locks, bad);
    end
  endtask

  task automatic test_load_abort;
    int vseen = 0;
    do_reset();
    b_req = 1;
    tick();
    b_req = 0; b_load = 1; b_seed = 10'h055;
    tick();
    b_load = 0;
    checks++;
    if (b_busy !== 0 || b_valid !== 0 || b_state !== 10'h055) begin
      errors++;
      $display("FAIL abort_load: busy=%b v=%b st=%h want 0/0/055",
               b_busy, b_valid, b_state);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b_valid === 1'b1 || b_busy === 1'b1) vseen++;
    end
    checks++;
    if (vseen != 0 || b_state !== 10'h055) begin
      errors++;
      $display("FAIL abort_after: stray=%0d st=%h want 0/055", vseen, b_state);
    end
    b_load = 1; b_req = 1; b_seed = 10'h0AA;
    tick();
    b_load = 0; b_req = 0;
    vseen = 0;
    checks++;
    if (b_busy !== 0 || b_state !== 10'h0AA) begin
      errors++;
      $display("FAIL load_vs_req: busy=%b st=%h want 0/0aa", b_busy, b_state);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b_valid === 1'b1) vseen++;
    end
    checks++;
    if (vseen != 0 || b_state !== 10'h0AA) begin
      errors++;
      $display("FAIL load_vs_req_after: valids=%0d st=%h want 0/0aa",
               vseen, b_state);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp [4] = '{10'h200, 10'h300, 10'h380, 10'h3C0};
    do_reset();
    a_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (a_valid !== 1 || a_busy !== 0 || a_value !== exp[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: v=%b busy=%b val=%h want 1/0/%h",
                 i, a_valid, a_busy, a_value, exp[i]);
      end
    end
    a_req = 0;
    tick();
    checks++;
    if (a_valid !== 0 || a_value !== 10'h3C0) begin
      errors++;
      $display("FAIL b2b_end: v=%b val=%h want 0/3c0", a_valid, a_value);
    end
  endtask

  task automatic test_random;
    int left = 0;
    logic [9:0] ms = 10'h000, mv = 10'h000;
    logic ml, mw, mval;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      b_en   = ($urandom % 2) == 0;
      b_req  = ($urandom % 3) == 0;
      b_load = ($urandom % 16) == 0;
      b_seed = (($urandom % 3) == 0) ? 10'h3FF : 10'($urandom);
      tick();
      ml = 0; mw = 0; mval = 0;
      if (b_load) begin
        ms = b_seed;
        left = 0;
      end else if (left > 0) begin
        model_adv(ms, ml, mw);
        left--;
        if (left == 0) begin mval = 1; mv = ms; end
      end else if (b_req) begin
        model_adv(ms, ml, mw);
        left = 2;
      end else if (b_en) begin
        model_adv(ms, ml, mw);
      end
      checks++;
      if (b_state !== ms || b_busy !== (left > 0) ||
          b_valid !== mval || b_value !== mv ||
          b_lock !== ml || b_wrap !== mw) begin
        errors++;
        $display("FAIL rand[%0d]: st=%h busy=%b v=%b val=%h lk=%b wr=%b want %h/%b/%b/%h/%b/%b",
                 i, b_state, b_busy, b_valid, b_value, b_lock, b_wrap,
                 ms, (left > 0), mval, mv, ml, mw);
      end
    end
    b_en = 0; b_req = 0; b_load = 0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_lockup();
    test_draw_steps3();
    test_period();
    test_load_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
